// File: rtl/csr_bank_v2.sv
// Avalon-MM CSR slave for the capture engine: config, live status, sticky W1C
// interrupt flags, a saturating packet counter and an ID word, plus a level irq.
module csr_bank_v2 #(
  parameter int          DATA_W  = 32,
  parameter int          ADDR_W  = 4,
  parameter int          CNT_W   = DATA_W,
  parameter logic [31:0] VERSION = 32'h0002_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     address,
  input  logic                  read,
  input  logic                  write,
  input  logic [DATA_W-1:0]     writedata,
  input  logic [DATA_W/8-1:0]   byteenable,
  output logic [DATA_W-1:0]     readdata,
  output logic                  readdatavalid,
  input  logic [1:0]            state,
  input  logic                  busy,
  input  logic                  done,
  input  logic                  pkt_done,
  input  logic                  overflow,
  input  logic [DATA_W-1:0]     wr_ptr,
  output logic                  out_enable,
  output logic                  out_start,
  output logic                  out_soft_rst,
  output logic [DATA_W-1:0]     out_buf_start,
  output logic [DATA_W-1:0]     out_buf_size,
  output logic                  irq
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [DATA_W-1:0] ID_VAL = DATA_W'(VERSION);

  localparam logic [ADDR_W-1:0] A_CTRL      = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_STATUS    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_IRQ_STAT  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_IRQ_EN    = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_BUF_START = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_BUF_SIZE  = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_WR_PTR    = ADDR_W'(6);
  localparam logic [ADDR_W-1:0] A_PKT_CNT   = ADDR_W'(7);
  localparam logic [ADDR_W-1:0] A_ID        = ADDR_W'(8);

  // Handshake: a read strobe sampled on a clock edge is answered by
  // readdatavalid exactly one cycle later; readdata holds between answers.

  logic              ctrl_en_q, ctrl_en_d;
  logic              start_q, start_d;
  logic              soft_rst_q, soft_rst_d;
  logic [1:0]        irq_stat_q, irq_stat_d;
  logic [1:0]        irq_en_q, irq_en_d;
  logic [DATA_W-1:0] buf_start_q, buf_start_d;
  logic [DATA_W-1:0] buf_size_q, buf_size_d;
  logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic              irq_q, irq_d;
  logic [DATA_W-1:0] readdata_q, readdata_d;
  logic              rdv_q, rdv_d;

  logic [DATA_W-1:0] rd_mux;
  logic [DATA_W-1:0] status_val;
  logic [1:0]        w1c_mask;

  function automatic logic [DATA_W-1:0] be_merge(input logic [DATA_W-1:0] old_v,
                                                 input logic [DATA_W-1:0] new_v,
                                                 input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] res;
    res = old_v;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) res[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return res;
  endfunction

  always_comb begin
    status_val             = '0;
    status_val[DATA_W-1]   = busy;
    status_val[DATA_W-2]   = done;
    status_val[1:0]        = state;

    case (address)
      A_CTRL:      rd_mux = DATA_W'(ctrl_en_q);
      A_STATUS:    rd_mux = status_val;
      A_IRQ_STAT:  rd_mux = DATA_W'(irq_stat_q);
      A_IRQ_EN:    rd_mux = DATA_W'(irq_en_q);
      A_BUF_START: rd_mux = buf_start_q;
      A_BUF_SIZE:  rd_mux = buf_size_q;
      A_WR_PTR:    rd_mux = wr_ptr;
      A_PKT_CNT:   rd_mux = DATA_W'(pkt_cnt_q);
      A_ID:        rd_mux = ID_VAL;
      default:     rd_mux = '0;
    endcase
  end

  always_comb begin
    ctrl_en_d   = ctrl_en_q;
    start_d     = 1'b0;
    soft_rst_d  = 1'b0;
    irq_en_d    = irq_en_q;
    buf_start_d = buf_start_q;
    buf_size_d  = buf_size_q;
    pkt_cnt_d   = pkt_cnt_q;
    w1c_mask    = 2'b00;

    if (write && address == A_CTRL && byteenable[0]) begin
      ctrl_en_d  = writedata[0];
      start_d    = writedata[1];
      soft_rst_d = writedata[2];
    end
    if (write && address == A_IRQ_STAT && byteenable[0]) w1c_mask = writedata[1:0];
    if (write && address == A_IRQ_EN && byteenable[0])   irq_en_d = writedata[1:0];
    if (write && address == A_BUF_START) buf_start_d = be_merge(buf_start_q, writedata, byteenable);
    if (write && address == A_BUF_SIZE)  buf_size_d  = be_merge(buf_size_q, writedata, byteenable);

    // New events are OR'd in after the clear so a coincident event survives.
    irq_stat_d = (irq_stat_q & ~w1c_mask) | {overflow, pkt_done};

    if (write && address == A_PKT_CNT) begin
      pkt_cnt_d = CNT_W'(pkt_done);
    end else if (pkt_done && pkt_cnt_q != {CNT_W{1'b1}}) begin
      pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
    end

    irq_d      = |(irq_stat_q & irq_en_q);
    readdata_d = read ? rd_mux : readdata_q;
    rdv_d      = read;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_en_q   <= 1'b0;
      start_q     <= 1'b0;
      soft_rst_q  <= 1'b0;
      irq_stat_q  <= '0;
      irq_en_q    <= '0;
      buf_start_q <= '0;
      buf_size_q  <= '0;
      pkt_cnt_q   <= '0;
      irq_q       <= 1'b0;
      readdata_q  <= '0;
      rdv_q       <= 1'b0;
    end else begin
      ctrl_en_q   <= ctrl_en_d;
      start_q     <= start_d;
      soft_rst_q  <= soft_rst_d;
      irq_stat_q  <= irq_stat_d;
      irq_en_q    <= irq_en_d;
      buf_start_q <= buf_start_d;
      buf_size_q  <= buf_size_d;
      pkt_cnt_q   <= pkt_cnt_d;
      irq_q       <= irq_d;
      readdata_q  <= readdata_d;
      rdv_q       <= rdv_d;
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = rdv_q;
  assign out_enable    = ctrl_en_q;
  assign out_start     = start_q;
  assign out_soft_rst  = soft_rst_q;
  assign out_buf_start = buf_start_q;
  assign out_buf_size  = buf_size_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_csr_bank_v2.sv
// Bench for csr_bank_v2: a 32-bit counter instance and a 4-bit counter instance
// share one bus; a register model predicts read data into per-instance queues.
module tb_csr_bank_v2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic [1:0]  state = '0;
  logic        busy = 1'b0;
  logic        done = 1'b0;
  logic        pkt_done = 1'b0;
  logic        overflow = 1'b0;
  logic [31:0] wr_ptr = '0;

  logic [31:0] readdata, out_buf_start, out_buf_size;
  logic        readdatavalid, out_enable, out_start, out_soft_rst, irq;
  logic [31:0] readdata4, out_buf_start4, out_buf_size4;
  logic        readdatavalid4, out_enable4, out_start4, out_soft_rst4, irq4;

  csr_bank_v2 #(.DATA_W(32), .ADDR_W(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata),
    .readdatavalid(readdatavalid), .state(state), .busy(busy), .done(done),
    .pkt_done(pkt_done), .overflow(overflow), .wr_ptr(wr_ptr),
    .out_enable(out_enable), .out_start(out_start), .out_soft_rst(out_soft_rst),
    .out_buf_start(out_buf_start), .out_buf_size(out_buf_size), .irq(irq)
  );

  csr_bank_v2 #(.DATA_W(32), .ADDR_W(4), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata4),
    .readdatavalid(readdatavalid4), .state(state), .busy(busy), .done(done),
    .pkt_done(pkt_done), .overflow(overflow), .wr_ptr(wr_ptr),
    .out_enable(out_enable4), .out_start(out_start4), .out_soft_rst(out_soft_rst4),
    .out_buf_start(out_buf_start4), .out_buf_size(out_buf_size4), .irq(irq4)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp4_q[$];

  logic        m_en;
  logic [1:0]  m_stat, m_irq_en;
  logic [31:0] m_bs, m_bsz, m_cnt;
  logic [3:0]  m_cnt4;
  logic        m_irq;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_en = 1'b0; m_stat = '0; m_irq_en = '0; m_bs = '0; m_bsz = '0;
    m_cnt = '0; m_cnt4 = '0; m_irq = 1'b0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_read(input logic [3:0] a, input bit narrow);
    case (a)
      4'h0: return {31'b0, m_en};
      4'h1: return {busy, done, 28'b0, state};
      4'h2: return {30'b0, m_stat};
      4'h3: return {30'b0, m_irq_en};
      4'h4: return m_bs;
      4'h5: return m_bsz;
      4'h6: return wr_ptr;
      4'h7: return narrow ? {28'b0, m_cnt4} : m_cnt;
      4'h8: return 32'h0002_0000;
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Called at posedge+1; drives one bus cycle and returns at the next posedge+1.
  task automatic bus_cycle(input logic rd, input logic wr, input logic [3:0] a,
                           input logic [31:0] wd, input logic [3:0] be,
                           input logic pk, input logic ov);
    read = rd; write = wr; address = a; writedata = wd; byteenable = be;
    pkt_done = pk; overflow = ov;
    if (rd) begin
      exp_q.push_back(exp_read(a, 1'b0));
      exp4_q.push_back(exp_read(a, 1'b1));
    end
    m_irq = |(m_stat & m_irq_en);
    if (wr) begin
      case (a)
        4'h0: if (be[0]) m_en = wd[0];
        4'h2: if (be[0]) m_stat = m_stat & ~wd[1:0];
        4'h3: if (be[0]) m_irq_en = wd[1:0];
        4'h4: m_bs = merge(m_bs, wd, be);
        4'h5: m_bsz = merge(m_bsz, wd, be);
        default: ;
      endcase
    end
    m_stat = m_stat | {ov, pk};
    if (wr && a == 4'h7) begin
      m_cnt = {31'b0, pk};
      m_cnt4 = {3'b0, pk};
    end else if (pk) begin
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      if (m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 4'd1;
    end
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0; pkt_done = 1'b0; overflow = 1'b0; byteenable = '0;
  endtask

  task automatic idle();
    bus_cycle(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 1'b0);
  endtask
  task automatic wr_reg(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    bus_cycle(1'b0, 1'b1, a, d, be, 1'b0, 1'b0);
  endtask
  task automatic rd_reg(input logic [3:0] a);
    bus_cycle(1'b1, 1'b0, a, 32'h0, 4'h0, 1'b0, 1'b0);
  endtask
  task automatic pulse_pkt();
    bus_cycle(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 1'b0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_readdata"}, readdata, 32'h0);
    chk({tag, "_rdv"}, {31'b0, readdatavalid}, 32'h0);
    chk({tag, "_irq"}, {31'b0, irq}, 32'h0);
    chk({tag, "_enable"}, {31'b0, out_enable}, 32'h0);
    chk({tag, "_start"}, {31'b0, out_start}, 32'h0);
    chk({tag, "_soft_rst"}, {31'b0, out_soft_rst}, 32'h0);
    chk({tag, "_buf_start"}, out_buf_start, 32'h0);
    chk({tag, "_buf_size"}, out_buf_size, 32'h0);
  endtask

  // ---------------- read-data monitor ----------------
  always @(negedge clk) begin
    if (readdatavalid) begin
      if (exp_q.size() == 0) chk("rdv_spurious", 32'h1, 32'h0);
      else chk("rdata", readdata, exp_q.pop_front());
    end
    if (readdatavalid4) begin
      if (exp4_q.size() == 0) chk("rdv4_spurious", 32'h1, 32'h0);
      else chk("rdata4", readdata4, exp4_q.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    reset = 1'b0;

    // ID, unmapped address, readdata hold
    rd_reg(4'h8);
    idle();
    idle();
    chk("rdata_hold", readdata, 32'h0002_0000);
    rd_reg(4'hF);

    // byte-enabled write
    wr_reg(4'h4, 32'hDEAD_BEEF, 4'b0011);
    chk("buf_start_be", out_buf_start, 32'h0000_BEEF);
    rd_reg(4'h4);

    // self-clearing command bits
    wr_reg(4'h0, 32'h3, 4'hF);
    chk("start_pulse", {31'b0, out_start}, 32'h1);
    chk("enable_set", {31'b0, out_enable}, 32'h1);
    idle();
    chk("start_clear", {31'b0, out_start}, 32'h0);
    rd_reg(4'h0);
    wr_reg(4'h0, 32'h5, 4'hF);
    chk("soft_rst_pulse", {31'b0, out_soft_rst}, 32'h1);
    idle();
    chk("soft_rst_clear", {31'b0, out_soft_rst}, 32'h0);
    chk("enable_kept", {31'b0, out_enable}, 32'h1);

    // interrupt path
    wr_reg(4'h3, 32'h1, 4'hF);
    pulse_pkt();
    chk("irq_lat1", {31'b0, irq}, 32'h0);
    idle();
    chk("irq_lat2", {31'b0, irq}, 32'h1);
    rd_reg(4'h2);
    wr_reg(4'h2, 32'h1, 4'hF);
    idle();
    chk("irq_cleared", {31'b0, irq}, 32'h0);
    bus_cycle(1'b0, 1'b1, 4'h2, 32'h1, 4'hF, 1'b1, 1'b0);
    rd_reg(4'h2);
    bus_cycle(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 1'b1);
    rd_reg(4'h2);

    // packet counter
    wr_reg(4'h7, 32'h0, 4'hF);
    repeat (3) pulse_pkt();
    rd_reg(4'h7);
    bus_cycle(1'b0, 1'b1, 4'h7, 32'h0, 4'hF, 1'b1, 1'b0);
    rd_reg(4'h7);
    repeat (20) pulse_pkt();
    rd_reg(4'h7);

    // read-during-write returns the old value
    bus_cycle(1'b1, 1'b1, 4'h5, 32'h1234_5678, 4'hF, 1'b0, 1'b0);
    rd_reg(4'h5);

    // live status and write pointer
    busy = 1'b1; done = 1'b0; state = 2'b10; wr_ptr = 32'hCAFE_0040;
    rd_reg(4'h1);
    rd_reg(4'h6);
    wr_reg(4'h1, 32'hFFFF_FFFF, 4'hF);
    rd_reg(4'h1);

    // random traffic against the model
    for (int i = 0; i < 200; i++) begin
      busy = 1'($urandom_range(0, 1));
      done = 1'($urandom_range(0, 1));
      state = 2'($urandom_range(0, 3));
      wr_ptr = $urandom;
      bus_cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
      chk("rnd_irq", {31'b0, irq}, {31'b0, m_irq});
      chk("rnd_enable", {31'b0, out_enable}, {31'b0, m_en});
      chk("rnd_buf_start", out_buf_start, m_bs);
      chk("rnd_buf_size", out_buf_size, m_bsz);
    end
    idle();

    // reset landing on a read: that read is never answered
    wr_reg(4'h3, 32'h3, 4'hF);
    reset = 1'b1;
    read = 1'b1; address = 4'h8;
    @(posedge clk); #1;
    read = 1'b0; reset = 1'b0;
    model_clear();
    chk_outputs_zero("mid_reset");
    idle();
    chk("post_reset_rdv", {31'b0, readdatavalid}, 32'h0);
    rd_reg(4'h3);
    idle();
    idle();

    chk("rdv_missing", exp_q.size(), 32'h0);
    chk("rdv4_missing", exp4_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
